// File: rtl/counter_updown_n_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared types for the parametrised up/down counter.
//   mode_e      : terminal-count behaviour (wrap, one-shot halt, reload)
//   cnt_state_e : run/halt state of the counter
// ---------------------------------------------------------------------------
package counter_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'b00,
      MODE_ONESHOT = 2'b01,
      MODE_RELOAD  = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } cnt_state_e;

endpackage

// File: rtl/counter_updown_n_if.sv
// ---------------------------------------------------------------------------
// counter_updown_n_if
// Control/status bundle of one counter instance.
//   load_n, d       : synchronous parallel load (active-low) and its data
//   enp, ent        : parallel and trickle count enables
//   up, mode        : direction and terminal behaviour
//   q, rco          : count value and combinational ripple carry
//   tc_pulse, halted: registered terminal pulse and one-shot halt flag
// master drives the controls, slave is the counter.
// ---------------------------------------------------------------------------
interface counter_updown_n_if
   import counter_pkg::*;
#(
   parameter int WIDTH = 4
);
   logic             load_n;
   logic [WIDTH-1:0] d;
   logic             enp;
   logic             ent;
   logic             up;
   mode_e            mode;
   logic [WIDTH-1:0] q;
   logic             rco;
   logic             tc_pulse;
   logic             halted;

   modport master (
      output load_n, d, enp, ent, up, mode,
      input  q, rco, tc_pulse, halted
   );

   modport slave (
      input  load_n, d, enp, ent, up, mode,
      output q, rco, tc_pulse, halted
   );
endinterface

// File: rtl/counter_updown_n_next_value.sv
// ---------------------------------------------------------------------------
// counter_next_value
// Combinational next-count logic.
//   i_q, i_reload : current count and reload register
//   i_up, i_mode  : direction and terminal behaviour
//   o_terminal    : count sits at the end of its range for this direction
//   o_halt_req    : a step now would enter the one-shot halt
//   o_next_q      : value q takes if a count step happens this edge
// ---------------------------------------------------------------------------
module counter_next_value
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 2**WIDTH
) (
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_reload,
   input  logic             i_up,
   input  mode_e            i_mode,
   output logic             o_terminal,
   output logic             o_halt_req,
   output logic [WIDTH-1:0] o_next_q
);
   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] w_wrap_q;

   always_comb begin
      o_terminal = i_up ? (i_q == MAX_Q) : (i_q == '0);
      w_wrap_q   = i_up ? '0 : MAX_Q;
      o_halt_req = 1'b0;
      o_next_q   = i_up ? (i_q + WIDTH'(1)) : (i_q - WIDTH'(1));
      if (o_terminal) begin
         case (i_mode)
            MODE_ONESHOT: begin
               o_next_q   = i_q;
               o_halt_req = 1'b1;
            end
            MODE_RELOAD: o_next_q = i_reload;
            default:     o_next_q = w_wrap_q;
         endcase
      end
   end
endmodule

// File: rtl/counter_updown_n.sv
// ---------------------------------------------------------------------------
// counter_updown_n
// Parametrised synchronous up/down mod-N counter with wrap, one-shot halt and
// auto-reload modes; rco is combinational so instances cascade on one edge.
//   clk  : clock, all state changes on the rising edge
//   clr  : synchronous active-high clear
//   bus  : counter_updown_n_if.slave (controls in, q/rco/tc_pulse/halted out)
//
// state   | meaning
// ST_RUN  | counting allowed when enp & ent
// ST_HALT | one-shot reached terminal; q frozen until load or clr
// ---------------------------------------------------------------------------
module counter_updown_n
   import counter_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int MODULUS     = 2**WIDTH,
   parameter int RESET_VALUE = 0
) (
   input  logic               clk,
   input  logic               clr,
   counter_updown_n_if.slave  bus
);
   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);

   cnt_state_e       r_state;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_reload;
   logic             r_tc;
   logic             r_halted;

   logic             w_terminal;
   logic             w_halt_req;
   logic [WIDTH-1:0] w_next_q;
   logic [WIDTH-1:0] w_load_q;
   logic             w_step;

   counter_next_value #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .i_q        (r_q),
      .i_reload   (r_reload),
      .i_up       (bus.up),
      .i_mode     (bus.mode),
      .o_terminal (w_terminal),
      .o_halt_req (w_halt_req),
      .o_next_q   (w_next_q)
   );

   // Load data above the modulus saturates so q never leaves its range.
   assign w_load_q = (bus.d > MAX_Q) ? MAX_Q : bus.d;
   assign w_step   = bus.enp & bus.ent & (r_state == ST_RUN);

   always_ff @(posedge clk) begin
      if (clr) begin
         r_q      <= RST_Q;
         r_reload <= RST_Q;
         r_state  <= ST_RUN;
         r_halted <= 1'b0;
         r_tc     <= 1'b0;
      end else if (!bus.load_n) begin
         r_q      <= w_load_q;
         r_reload <= w_load_q;
         r_state  <= ST_RUN;
         r_halted <= 1'b0;
         r_tc     <= 1'b0;
      end else begin
         r_tc <= 1'b0;
         if (w_step) begin
            r_q  <= w_next_q;
            r_tc <= w_terminal;
            if (w_halt_req) begin
               r_state  <= ST_HALT;
               r_halted <= 1'b1;
            end
         end
      end
   end

   assign bus.q        = r_q;
   assign bus.rco      = bus.ent & w_terminal;
   assign bus.tc_pulse = r_tc;
   assign bus.halted   = r_halted;
endmodule

// File: tb/tb_counter_updown_n.sv
module tb_counter_updown_n;
   import counter_pkg::*;

   logic clk;
   logic clr;

   counter_updown_n_if #(.WIDTH(4)) bus    ();
   counter_updown_n_if #(.WIDTH(4)) bus_c0 ();
   counter_updown_n_if #(.WIDTH(4)) bus_c1 ();

   counter_updown_n #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_dut (
      .clk (clk), .clr (clr), .bus (bus.slave));
   counter_updown_n #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_c0 (
      .clk (clk), .clr (clr), .bus (bus_c0.slave));
   counter_updown_n #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_c1 (
      .clk (clk), .clr (clr), .bus (bus_c1.slave));

   // Cascade: tens digit trickles on the units ripple carry, shares enp.
   assign bus_c1.ent = bus_c0.rco;
   assign bus_c1.enp = bus_c0.enp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      bit         sel;
      logic [7:0] q;
      logic       rco;
      logic       tc;
      logic       h;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Monitor: every pushed expectation describes the state right after the
   // previous rising edge; compare it on the falling edge.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         if (!e.sel) begin
            check({e.name, "_q"},      {4'h0, bus.q},     e.q);
            check({e.name, "_rco"},    {7'h0, bus.rco},   {7'h0, e.rco});
            check({e.name, "_tc"},     {7'h0, bus.tc_pulse}, {7'h0, e.tc});
            check({e.name, "_halted"}, {7'h0, bus.halted},   {7'h0, e.h});
         end else begin
            check({e.name, "_q10"}, {bus_c1.q, bus_c0.q}, e.q);
         end
      end
   end

   task automatic tick(input string nm, input logic [3:0] eq, input logic erco,
                       input logic etc, input logic eh);
      exp_t e;
      @(posedge clk);
      e.name = nm; e.sel = 1'b0; e.q = {4'h0, eq}; e.rco = erco; e.tc = etc; e.h = eh;
      sb.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic tick_c(input string nm, input logic [7:0] eq);
      exp_t e;
      @(posedge clk);
      e.name = nm; e.sel = 1'b1; e.q = eq; e.rco = 1'b0; e.tc = 1'b0; e.h = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] rel_seq [11];
      rel_seq = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd4, 4'd3};

      clr        = 1'b1;
      bus.load_n = 1'b1; bus.d = 4'd0; bus.enp = 1'b0; bus.ent = 1'b0;
      bus.up     = 1'b1; bus.mode = MODE_WRAP;
      bus_c0.load_n = 1'b1; bus_c0.d = 4'd0; bus_c0.enp = 1'b0; bus_c0.ent = 1'b1;
      bus_c0.up     = 1'b1; bus_c0.mode = MODE_WRAP;
      bus_c1.load_n = 1'b1; bus_c1.d = 4'd0; bus_c1.up = 1'b1; bus_c1.mode = MODE_WRAP;

      tick("reset", 4'd0, 1'b0, 1'b0, 1'b0);

      // 1: wrap up-count through 9 -> 0
      clr = 1'b0; bus.enp = 1'b1; bus.ent = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick("t1_wrap_up", 4'(k % 10), (k % 10) == 9, k == 10, 1'b0);
      end

      // 2: wrap down-count from 0, trickle enable gating
      bus.up = 1'b0; bus.load_n = 1'b0; bus.d = 4'd0;
      tick("t2_load0", 4'd0, 1'b1, 1'b0, 1'b0);
      bus.load_n = 1'b1;
      tick("t2_wrap_dn", 4'd9, 1'b0, 1'b1, 1'b0);
      tick("t2_dn", 4'd8, 1'b0, 1'b0, 1'b0);
      bus.load_n = 1'b0;
      tick("t2_load0b", 4'd0, 1'b1, 1'b0, 1'b0);
      bus.load_n = 1'b1; bus.ent = 1'b0;
      tick("t2_ent0", 4'd0, 1'b0, 1'b0, 1'b0);
      tick("t2_ent0b", 4'd0, 1'b0, 1'b0, 1'b0);

      // 3: one-shot halts at 9, load restarts
      bus.ent = 1'b1; bus.up = 1'b1; bus.mode = MODE_ONESHOT;
      bus.load_n = 1'b0; bus.d = 4'd7;
      tick("t3_load7", 4'd7, 1'b0, 1'b0, 1'b0);
      bus.load_n = 1'b1;
      tick("t3_8", 4'd8, 1'b0, 1'b0, 1'b0);
      tick("t3_9", 4'd9, 1'b1, 1'b0, 1'b0);
      tick("t3_halt", 4'd9, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         if (i == 3) bus.mode = MODE_WRAP;
         tick("t3_hold", 4'd9, 1'b1, 1'b0, 1'b1);
      end
      bus.load_n = 1'b0; bus.d = 4'd3;
      tick("t3_reload3", 4'd3, 1'b0, 1'b0, 1'b0);
      bus.load_n = 1'b1;
      tick("t3_resume", 4'd4, 1'b0, 1'b0, 1'b0);

      // 4: reload mode counting down from 4
      bus.mode = MODE_RELOAD; bus.up = 1'b0; bus.load_n = 1'b0; bus.d = 4'd4;
      tick("t4_load4", 4'd4, 1'b0, 1'b0, 1'b0);
      bus.load_n = 1'b1;
      for (int i = 0; i < 11; i++) begin
         tick("t4_reload", rel_seq[i], rel_seq[i] == 4'd0, rel_seq[i] == 4'd4, 1'b0);
      end

      // 5: clr beats load, saturating load, enp=0 hold at terminal
      clr = 1'b1; bus.load_n = 1'b0; bus.d = 4'd5;
      tick("t5_clr_load", 4'd0, 1'b1, 1'b0, 1'b0);
      clr = 1'b0; bus.d = 4'd12; bus.up = 1'b1;
      tick("t5_sat", 4'd9, 1'b1, 1'b0, 1'b0);
      bus.load_n = 1'b1; bus.enp = 1'b0;
      tick("t5_enp0", 4'd9, 1'b1, 1'b0, 1'b0);
      tick("t5_enp0b", 4'd9, 1'b1, 1'b0, 1'b0);

      // 6: two cascaded decades count 00..99 -> 00
      bus_c0.enp = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         tick_c("t6_cascade", {4'((k % 100) / 10), 4'(k % 10)});
      end
      bus_c0.enp = 1'b0;

      @(negedge clk);
      #1;
      check("sb_drain", 8'(sb.size()), 8'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/counter_updown_n.md
Name: counter_updown_n

Overview:
Parametrised synchronous up/down counter. It generalises the fixed 4-bit counter parts to any WIDTH and any MODULUS, such as decade or mod-N counters. It adds a one-shot halt mode and an auto-reload mode. A combinational ripple-carry output lets instances cascade synchronously. Used as a building block for dividers, timers and address generators.

Parameters:
WIDTH, 4, counter width in bits (>=2)
MODULUS, 2**WIDTH, count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
RESET_VALUE, 0, value of q and reload register after clr (< MODULUS)

Ports:
clk  in  1  clock, all state updates on rising edge
clr  in  1  reset; synchronous, active-high
load_n  in  1  synchronous parallel load, active-low
d  in  WIDTH  parallel load data
enp  in  1  count enable (parallel), active-high
ent  in  1  count enable (trickle), active-high; also gates rco
up  in  1  direction: 1 = up, 0 = down
mode  in  2  00 WRAP, 01 ONESHOT, 10 RELOAD, 11 reserved (behaves as WRAP)
q  out  WIDTH  current count
rco  out  1  ripple carry, combinational: ent & terminal
tc_pulse  out  1  registered, one-cycle pulse after a terminal transition
halted  out  1  high while in ST_HALT

Behaviour:
- Reset (clr=1 at edge): q=RESET_VALUE, reload_reg=RESET_VALUE, state=ST_RUN, halted=0, tc_pulse=0.
- Priority per edge: clr > load > count > hold.
- Terminal: up=1 and q==MODULUS-1, or up=0 and q==0.
- rco = ent & terminal, with no register. It does not depend on enp or state.
- Load (load_n=0): q <= min(d, MODULUS-1), saturating. reload_reg <= the same value. state <= ST_RUN, halted <= 0.
  - A load overrides ST_HALT.
  - A load takes effect regardless of enp/ent.
- Count step: occurs when enp & ent & state==ST_RUN & no clr/load. With no step, q holds.
- On a count step when not terminal: q <= q+1 (up) or q-1 (down).
- On a count step when terminal:
  - WRAP/11: q <= 0 (up) or MODULUS-1 (down).
  - ONESHOT: q holds the terminal value, state <= ST_HALT, halted <= 1.
  - RELOAD: q <= reload_reg, in either direction.
- tc_pulse <= 1 on the edge after any count step taken at terminal, else 0. It is cleared by clr and is not asserted by loads.
- State machine:
  - ST_RUN -> ST_HALT: ONESHOT terminal step only.
  - ST_HALT -> ST_RUN: load or clr only.
  - In ST_HALT, enp/ent/up/mode changes have no effect on q. rco still reflects ent & terminal for the current up.
- up or mode changes apply at the next edge. No pipeline, no internal latency beyond the one register stage.
- Reset or load mid-operation discards pending terminal/tc_pulse activity for that edge.
- Cascading: for stage k+1, tie ent[k+1] to rco[k] and share enp/clk. Multi-digit counts then advance on the same edge with no extra latency.

Decomposition:
- Shared package counter_pkg:
  - typedef enum logic[1:0] mode_e {MODE_WRAP, MODE_ONESHOT, MODE_RELOAD, MODE_RSVD}
  - typedef enum logic {ST_RUN, ST_HALT} cnt_state_e
- One natural sub-module: counter_next_value. It is combinational and computes terminal, the next q and the wrap target from q, up, mode, reload_reg and MODULUS.
- The top level holds the registers, the state machine and the priority logic.

Test Plan (WIDTH=4, MODULUS=10 unless stated):
1. clr 1 cycle; mode=WRAP, up=1, enp=ent=1; 12 clocks -> q 0,1..9,0,1. rco=1 only while q==9. tc_pulse=1 the cycle q becomes 0.
2. WRAP, up=0 from q=0 -> q=9 on the next edge, rco=1 while q==0 and ent=1. With ent=0 at q=0 -> rco=0 and q holds.
3. ONESHOT, load d=7, up=1 -> q 7,8,9, then halted=1 and q stays 9 for 5 further clocks. load_n=0 with d=3 -> q=3, halted=0, counting resumes.
4. RELOAD, load d=4, up=0 -> q 4,3,2,1,0,4,3. tc_pulse pulses once after each 0->4 reload.
5. clr=1 and load_n=0 on the same edge -> q=0. Load d=12 -> q=9 (saturated). enp=0, ent=1 at q=9 -> q holds, rco=1, no tc_pulse.
6. Two instances cascaded (ent1=rco0), WRAP, up, 100 clocks from 00 -> {q1,q0} steps 00..99 then 00. Both digits change on the same edge at 09->10 and 99->00.
